// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester round-robin arbiter feeding a single-entry register file write stage
module regfile_wr_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    localparam int NREG  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   pending
);

    logic              stage_valid;
    logic [ADDR_W-1:0] stage_addr;
    logic [DATA_W-1:0] stage_data;
    logic              last_grant;

    logic free;
    logic accept0;
    logic accept1;

    // The stage can take a new entry when empty or when its entry drains this cycle.
    assign free = !stage_valid || !wr_stall;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && free) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else if (req0_valid) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;

    assign wr_en   = stage_valid && !wr_stall;
    assign wr_addr = stage_addr;
    assign wr_data = stage_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
            last_grant  <= 1'b1;
        end else if (accept0) begin
            stage_valid <= 1'b1;
            stage_addr  <= req0_addr;
            stage_data  <= req0_data;
            last_grant  <= 1'b0;
        end else if (accept1) begin
            stage_valid <= 1'b1;
            stage_addr  <= req1_addr;
            stage_data  <= req1_data;
            last_grant  <= 1'b1;
        end else if (wr_en) begin
            stage_valid <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        if (stage_valid) begin
            pending[stage_addr] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - vector table plus commit scoreboard for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        wr_stall;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  pending;

    regfile_wr_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_stall   (wr_stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        v0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        r0;
        logic        r1;
        logic        wen;
        logic [7:0]  pend;
    } vec_t;

    vec_t        tbl[$];
    logic [18:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic st,
                       input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                       input logic r0, input logic r1, input logic wen, input logic [7:0] pend);
        vec_t v;
        v.rst = r;  v.stall = st;
        v.v0 = v0;  v.a0 = a0; v.d0 = d0;
        v.v1 = v1;  v.a1 = a1; v.d1 = d1;
        v.r0 = r0;  v.r1 = r1; v.wen = wen; v.pend = pend;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input logic r, input logic st, input logic wen, input logic [7:0] pend);
        add(r, st, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, wen, pend);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [18:0] e;
        @(negedge clk);
        rst = v.rst;      wr_stall = v.stall;
        req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
        #1;
        if (v.rst) begin
            sb.delete();
            chk($sformatf("v%0d reset wr_addr", idx), 32'(wr_addr), 32'd0);
            chk($sformatf("v%0d reset wr_data", idx), 32'(wr_data), 32'd0);
        end
        chk($sformatf("v%0d req0_ready", idx), 32'(req0_ready), 32'(v.r0));
        chk($sformatf("v%0d req1_ready", idx), 32'(req1_ready), 32'(v.r1));
        chk($sformatf("v%0d wr_en", idx), 32'(wr_en), 32'(v.wen));
        chk($sformatf("v%0d pending", idx), 32'(pending), 32'(v.pend));
        if (wr_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL v%0d commit: got write addr %0d data 0x%0h expected no write", idx, wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d commit addr", idx), 32'(wr_addr), 32'(e[18:16]));
                chk($sformatf("v%0d commit data", idx), 32'(wr_data), 32'(e[15:0]));
            end
        end
        if (v.r0) sb.push_back({v.a0, v.d0});
        if (v.r1) sb.push_back({v.a1, v.d1});
    endtask

    initial begin
        rst = 1'b1; wr_stall = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        // reset: readies held low even with both requesters valid
        add(1, 0, 1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 0, 0, 0, 8'h00);
        // single write
        add(0, 0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, 1, 0, 0, 8'h00);
        add_idle(0, 0, 1, 8'h08);
        add_idle(0, 0, 0, 8'h00);
        // tie after reset
        add_idle(1, 0, 0, 8'h00);
        add(0, 0, 1, 3'd5, 16'hAAAA, 1, 3'd6, 16'hBBBB, 1, 0, 0, 8'h00);
        add(0, 0, 1, 3'd5, 16'hAAAA, 1, 3'd6, 16'hBBBB, 0, 1, 1, 8'h20);
        add_idle(0, 0, 1, 8'h40);
        add_idle(0, 0, 0, 8'h00);
        // continuous contention alternates
        add(0, 0, 1, 3'd0, 16'h0100, 1, 3'd1, 16'h0101, 1, 0, 0, 8'h00);
        add(0, 0, 1, 3'd0, 16'h0100, 1, 3'd1, 16'h0101, 0, 1, 1, 8'h01);
        add(0, 0, 1, 3'd0, 16'h0100, 1, 3'd1, 16'h0101, 1, 0, 1, 8'h02);
        add(0, 0, 1, 3'd0, 16'h0100, 1, 3'd1, 16'h0101, 0, 1, 1, 8'h01);
        add_idle(0, 0, 1, 8'h02);
        add_idle(0, 0, 0, 8'h00);
        // stall holds a loaded stage for three cycles
        add(0, 0, 0, 3'd0, 16'h0, 1, 3'd2, 16'h00FF, 0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++)
            add(0, 1, 1, 3'd4, 16'h4444, 1, 3'd5, 16'h5555, 0, 0, 0, 8'h04);
        add(0, 0, 1, 3'd4, 16'h4444, 0, 3'd0, 16'h0, 1, 0, 1, 8'h04);
        add_idle(0, 0, 1, 8'h10);
        add_idle(0, 0, 0, 8'h00);
        // stall with an empty stage still accepts
        add(0, 1, 1, 3'd3, 16'h3333, 0, 3'd0, 16'h0, 1, 0, 0, 8'h00);
        add(0, 1, 0, 3'd0, 16'h0, 1, 3'd1, 16'h1111, 0, 0, 0, 8'h08);
        add_idle(0, 0, 1, 8'h08);
        add_idle(0, 0, 0, 8'h00);
        // requester 1 streaming
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 3'd0, 16'h0, 1, i[2:0], 16'(i), 0, 1, (i > 0), (i > 0) ? 8'(1 << (i - 1)) : 8'h00);
        add_idle(0, 0, 1, 8'h80);
        add_idle(0, 0, 0, 8'h00);
        // reset while a write is staged
        add(0, 0, 1, 3'd7, 16'hDEAD, 0, 3'd0, 16'h0, 1, 0, 0, 8'h00);
        add_idle(0, 1, 0, 8'h80);
        add_idle(1, 1, 0, 8'h00);
        add_idle(0, 0, 0, 8'h00);
        add(0, 0, 1, 3'd1, 16'h0A0A, 1, 3'd2, 16'h0B0B, 1, 0, 0, 8'h00);
        add_idle(0, 0, 1, 8'h02);
        add_idle(0, 0, 0, 8'h00);

        foreach (tbl[i]) apply(tbl[i], i);

        // reset clears the stage asynchronously, between clock edges
        @(negedge clk);
        wr_stall = 1'b1;
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'h5555;
        #1;
        chk("async load ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("async staged pending", 32'(pending), 32'h08);
        chk("async staged wr_en", 32'(wr_en), 32'd0);
        rst = 1'b1;
        #1;
        chk("async rst pending", 32'(pending), 32'h00);
        chk("async rst wr_data", 32'(wr_data), 32'h0);
        chk("async rst wr_addr", 32'(wr_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wr_stall = 1'b0;
        #1;
        chk("post rst wr_en", 32'(wr_en), 32'd0);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, register data width.
REQ-002 Parameter: ADDR_W, 3, register address width; register count NREG = 2**ADDR_W.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: req0_valid  input  1  requester 0 has a write pending.
REQ-006 Port: req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 Port: req0_data  input  DATA_W  requester 0 write data.
REQ-008 Port: req0_ready  output  1  requester 0 write accepted this cycle when high with req0_valid.
REQ-009 Port: req1_valid, req1_addr, req1_data, req1_ready; same directions, widths and meanings as requester 0.
REQ-010 Port: wr_stall  input  1  register file write port unavailable this cycle.
REQ-011 Port: wr_en  output  1  write strobe to register file.
REQ-012 Port: wr_addr  output  ADDR_W  write address to register file.
REQ-013 Port: wr_data  output  DATA_W  write data to register file.
REQ-014 Port: pending  output  NREG  bit n high while a write to register n is accepted but not yet committed.

Function
REQ-015 Block SHALL contain one output stage: stage_valid, stage_addr, stage_data, plus a round-robin pointer last_grant (1 bit).
REQ-016 Handshake: a request is accepted in a cycle where reqX_valid && reqX_ready at the rising edge; accepted data SHALL be captured into the stage at that edge.
REQ-017 Stage free condition: free = !stage_valid || !wr_stall.
REQ-018 Grant with one valid requester and free high: that requester's ready SHALL be 1, the other's 0.
REQ-019 Grant with both valid and free high: requester != last_grant SHALL get ready=1; the other ready=0.
REQ-020 With free low, req0_ready and req1_ready SHALL both be 0.
REQ-021 At most one ready SHALL be high in any cycle; ready SHALL depend combinationally on valids, stage state, wr_stall and last_grant only, never on reqX_data/addr.
REQ-022 last_grant SHALL update to the accepted requester's index only on an acceptance edge; otherwise it SHALL hold.
REQ-023 wr_en SHALL equal stage_valid && !wr_stall; wr_addr = stage_addr; wr_data = stage_data (combinational from stage).
REQ-024 Stage update each edge: acceptance loads new entry (stage_valid=1); else if wr_en, stage_valid clears; else stage holds unchanged.
REQ-025 Latency: request accepted at edge N SHALL appear on wr_en in cycle N..N+1 window, i.e. wr_en high in the cycle immediately after acceptance when wr_stall low; back-to-back acceptance every cycle SHALL sustain one write per cycle.
REQ-026 wr_stall high with stage_valid: stage_addr/stage_data SHALL hold stable until wr_en commits them; no write lost or duplicated.
REQ-027 Fairness: with both requesters continuously valid and no stall, grants SHALL alternate 0,1,0,1...; no requester waits more than one grant.
REQ-028 Same-address requests from both requesters SHALL both be committed, in grant order; no merging.
REQ-029 pending SHALL be one-hot of stage_addr when stage_valid, else all zeros.

Reset
REQ-030 While rst high: stage_valid=0, stage_addr=0, stage_data=0, last_grant=1 (requester 0 wins first tie).
REQ-031 Outputs in reset: wr_en=0, wr_addr=0, wr_data=0, pending=0, req0_ready=req1_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard any staged write without asserting wr_en.
REQ-033 First rising edge after rst deassertion SHALL accept requests normally.

Verification
REQ-034 Single: req0 valid addr=3 data=0x1234 one cycle, stall low -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234, pending=0x08; following cycle pending=0.
REQ-035 Tie after reset: both valid, req0 (5,0xAAAA), req1 (6,0xBBBB) held -> commits (5,0xAAAA) then (6,0xBBBB) on consecutive cycles; ready alternates 0 then 1.
REQ-036 Stall: stage holds (2,0x00FF), wr_stall high 3 cycles -> wr_en=0, both ready=0, pending=0x04 throughout; wr_en=1 with (2,0x00FF) exactly once on first unstalled cycle.
REQ-037 Stream: req1 alone valid 8 cycles, addr=i, data=i -> wr_en high 8 consecutive cycles, no gaps, data in order.
REQ-038 Reset mid-flight: stage loaded (7,0xDEAD), rst pulsed -> wr_en never asserts for it; pending=0; post-reset tie grants requester 0.
